// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a granted port keeps the resource for up to
// weight[g] acknowledged transfers, then the grant rotates to the next eligible port.
module wrr_arbiter #(
   parameter int unsigned PORTS        = 4,
   parameter int unsigned WEIGHT_WIDTH = 4,
   parameter string       LSB_PRIORITY = "LOW"
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORTS-1:0]              request,
   input  logic [PORTS-1:0]              acknowledge,
   input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
   output logic [PORTS-1:0]              grant,
   output logic                          grant_valid,
   output logic [$clog2(PORTS)-1:0]      grant_encoded,
   output logic [WEIGHT_WIDTH-1:0]       credit
);

   localparam int unsigned IW         = $clog2(PORTS);
   localparam bit          HIGH_FIRST = (LSB_PRIORITY == "HIGH");

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                  state;
   logic [IW-1:0]           last;
   logic [PORTS-1:0]        eligible;
   logic                    pick_valid;
   logic [IW-1:0]           pick;
   logic [WEIGHT_WIDTH-1:0] pick_weight;
   int unsigned             idx;
   logic                    ack_g_c;
   logic                    release_c;
   logic                    take_c;

   // A zero weight masks the request entirely.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         eligible[i] = request[i] && (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
      end
   end

   // Rotating search starting just past the last granted index; `last` itself is checked last.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      idx        = 0;
      for (int unsigned k = 1; k <= PORTS; k++) begin
         idx = HIGH_FIRST ? (32'(last) + PORTS - k) % PORTS
                          : (32'(last) + k) % PORTS;
         if (!pick_valid && eligible[IW'(idx)]) begin
            pick_valid = 1'b1;
            pick       = IW'(idx);
         end
      end
   end

   assign pick_weight = weight[pick*WEIGHT_WIDTH +: WEIGHT_WIDTH];

   // Only the granted port's acknowledge is meaningful.
   assign ack_g_c   = (state == S_GRANT) && acknowledge[grant_encoded];
   assign release_c = (ack_g_c && (credit == WEIGHT_WIDTH'(1))) || !request[grant_encoded];
   assign take_c    = (state == S_IDLE) || release_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         last          <= IW'(PORTS - 1);
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         credit        <= '0;
      end else if (take_c && pick_valid) begin
         state         <= S_GRANT;
         last          <= pick;
         grant         <= PORTS'(1) << pick;
         grant_valid   <= 1'b1;
         grant_encoded <= pick;
         credit        <= pick_weight;
      end else if (take_c) begin
         state         <= S_IDLE;
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         credit        <= '0;
      end else if (ack_g_c) begin
         credit        <= credit - WEIGHT_WIDTH'(1);
      end
   end

endmodule
